// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC per instruction,
// driving ALU/register-file controls from a 9-bit instruction word.
module instruction_sequencer (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  output logic        inst_req,
  output logic [7:0]  inst_addr,
  input  logic        inst_valid,
  input  logic [8:0]  inst,
  output logic [4:0]  alu_op,
  output logic        alu_imm_sel,
  output logic [7:0]  imm_out,
  output logic [4:0]  reg_addr,
  output logic        reg_we,
  input  logic [7:0]  alu_result,
  input  logic        branch_comp_pass,
  output logic        busy,
  output logic        done,
  output logic [15:0] instr_count
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SRL  = 5'd3,
    ALU_BREG = 5'd4,  ALU_SUBU = 5'd5,  ALU_ADDU = 5'd6,  ALU_AND  = 5'd7,
    ALU_SLRA = 5'd8,  ALU_SEQ  = 5'd9,  ALU_MOD  = 5'd10, ALU_ADDI = 5'd11,
    ALU_BNE  = 5'd12, ALU_BEZ  = 5'd13, ALU_MV   = 5'd14
  } alu_op_e;

  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED
  } state_e;

  function automatic logic is_branch(input logic [3:0] opc);
    return ({1'b0, opc} == ALU_BNE) || ({1'b0, opc} == ALU_BEZ);
  endfunction

  function automatic logic is_imm(input logic [3:0] opc);
    logic [4:0] op;
    op = {1'b0, opc};
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SLRA) ||
           (op == ALU_ADDI) || is_branch(opc);
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [3:0]  opc_q, opc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        inst_req_q, inst_req_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic        imm_sel_q, imm_sel_d;
  logic [7:0]  imm_q, imm_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic        reg_we_q, reg_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opc_d      = opc_q;
    cnt_d      = cnt_q;
    inst_req_d = inst_req_q;
    alu_op_d   = alu_op_q;
    imm_sel_d  = imm_sel_q;
    imm_d      = imm_q;
    reg_addr_d = reg_addr_q;
    reg_we_d   = reg_we_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d    = S_FETCH;
          pc_d       = 8'd0;
          cnt_d      = 16'd0;
          inst_req_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      S_FETCH: begin
        // Decode outputs are registered on acceptance so they are valid
        // for the whole DECODE cycle.
        if (inst_valid) begin
          state_d    = S_DECODE;
          opc_d      = inst[8:5];
          inst_req_d = 1'b0;
          alu_op_d   = (inst[8:5] == OPC_HALT) ? ALU_ADD : {1'b0, inst[8:5]};
          imm_sel_d  = (inst[8:5] != OPC_HALT) && is_imm(inst[8:5]);
          imm_d      = {3'b000, inst[4:0]};
          reg_addr_d = inst[4:0];
        end
      end
      S_DECODE: begin
        if (opc_q == OPC_HALT) begin
          state_d    = S_HALTED;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          alu_op_d   = ALU_ADD;
          imm_sel_d  = 1'b0;
          imm_d      = 8'd0;
          reg_addr_d = 5'd0;
        end else begin
          state_d  = S_EXEC;
          reg_we_d = !is_branch(opc_q);
        end
      end
      S_EXEC: begin
        state_d    = S_FETCH;
        inst_req_d = 1'b1;
        reg_we_d   = 1'b0;
        alu_op_d   = ALU_ADD;
        imm_sel_d  = 1'b0;
        imm_d      = 8'd0;
        reg_addr_d = 5'd0;
        pc_d       = (is_branch(opc_q) && branch_comp_pass) ? alu_result : pc_q + 8'd1;
        cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= 8'd0;
      opc_q      <= 4'd0;
      cnt_q      <= 16'd0;
      inst_req_q <= 1'b0;
      alu_op_q   <= ALU_ADD;
      imm_sel_q  <= 1'b0;
      imm_q      <= 8'd0;
      reg_addr_q <= 5'd0;
      reg_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opc_q      <= opc_d;
      cnt_q      <= cnt_d;
      inst_req_q <= inst_req_d;
      alu_op_q   <= alu_op_d;
      imm_sel_q  <= imm_sel_d;
      imm_q      <= imm_d;
      reg_addr_q <= reg_addr_d;
      reg_we_q   <= reg_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign inst_req    = inst_req_q;
  assign inst_addr   = pc_q;
  assign alu_op      = alu_op_q;
  assign alu_imm_sel = imm_sel_q;
  assign imm_out     = imm_q;
  assign reg_addr    = reg_addr_q;
  assign reg_we      = reg_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a variable-latency instruction memory.
module tb_instruction_sequencer;

  logic        CLK = 1'b0;
  logic        reset, start;
  logic        inst_req;
  logic [7:0]  inst_addr;
  logic        inst_valid = 1'b0;
  logic [8:0]  inst = 9'd0;
  logic [4:0]  alu_op;
  logic        alu_imm_sel;
  logic [7:0]  imm_out;
  logic [4:0]  reg_addr;
  logic        reg_we;
  logic [7:0]  alu_result;
  logic        branch_comp_pass;
  logic        busy, done;
  logic [15:0] instr_count;

  logic [8:0]  mem [256];
  int          lat = 0;
  int          wait_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  instruction_sequencer dut (
    .CLK(CLK), .reset(reset), .start(start),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .inst(inst),
    .alu_op(alu_op), .alu_imm_sel(alu_imm_sel), .imm_out(imm_out),
    .reg_addr(reg_addr), .reg_we(reg_we),
    .alu_result(alu_result), .branch_comp_pass(branch_comp_pass),
    .busy(busy), .done(done), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  // Memory answers on the (lat+1)-th cycle of a request.
  always @(negedge CLK) begin
    if (inst_req) begin
      if (wait_cnt >= lat) begin
        inst_valid = 1'b1;
        inst = mem[inst_addr];
      end else begin
        inst_valid = 1'b0;
      end
      wait_cnt++;
    end else begin
      inst_valid = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (inst_req && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " accept"}, inst_req, 0);
  endtask

  task automatic step(input string tag, input logic [7:0] addr, input logic we);
    chk({tag, " req"}, inst_req, 1);
    chk({tag, " addr"}, inst_addr, addr);
    wait_accept(tag);
    tick();
    chk({tag, " we"}, reg_we, we);
    tick();
  endtask

  task automatic step_halt(input string tag, input logic [7:0] addr);
    chk({tag, " req"}, inst_req, 1);
    chk({tag, " addr"}, inst_addr, addr);
    wait_accept(tag);
    tick();
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; alu_result = 8'd0; branch_comp_pass = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 9'd0;
    tick(); tick();
    reset = 1'b0;

    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst req", inst_req, 0);
    chk("rst addr", inst_addr, 0);
    chk("rst count", instr_count, 0);
    chk("rst alu_op", alu_op, 0);
    chk("rst we", reg_we, 0);
    chk("rst imm", imm_out, 0);

    // Straight-line program; start is cycle 1, HALTED reached at cycle 10
    mem[0] = 9'h003; mem[1] = 9'h165; mem[2] = 9'h1E0;
    do_start();
    chk("A f0 req", inst_req, 1);
    chk("A f0 addr", inst_addr, 0);
    chk("A f0 busy", busy, 1);
    tick();
    chk("A d0 op", alu_op, 0);
    chk("A d0 immsel", alu_imm_sel, 0);
    chk("A d0 raddr", reg_addr, 3);
    chk("A d0 we", reg_we, 0);
    chk("A d0 req", inst_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("A e0 we", reg_we, 1);
    chk("A e0 raddr", reg_addr, 3);
    tick();
    chk("A f1 addr", inst_addr, 1);
    chk("A f1 we", reg_we, 0);
    chk("A f1 op", alu_op, 0);
    chk("A f1 count", instr_count, 1);
    tick();
    chk("A d1 op", alu_op, 11);
    chk("A d1 immsel", alu_imm_sel, 1);
    chk("A d1 imm", imm_out, 8'h05);
    chk("A d1 raddr", reg_addr, 5);
    tick();
    chk("A e1 we", reg_we, 1);
    tick();
    chk("A f2 addr", inst_addr, 2);
    chk("A f2 count", instr_count, 2);
    tick();
    chk("A d2 busy", busy, 1);
    chk("A d2 done", done, 0);
    tick();
    chk("A done", done, 1);
    chk("A busy", busy, 0);
    chk("A count", instr_count, 2);
    chk("A halt we", reg_we, 0);
    chk("A halt req", inst_req, 0);

    // Taken branch: BNE at PC 4 jumps to 9; flag high during ADDs is ignored
    for (int i = 0; i < 4; i++) mem[i] = 9'h001;
    mem[4] = 9'h189; mem[9] = 9'h1E0;
    alu_result = 8'h09; branch_comp_pass = 1'b1;
    do_start();
    chk("B count0", instr_count, 0);
    for (int i = 0; i < 4; i++) step("B add", 8'(i), 1'b1);
    step("B bne", 8'd4, 1'b0);
    step_halt("B halt", 8'd9);
    chk("B count", instr_count, 5);

    // Not-taken branch falls through to 5
    mem[5] = 9'h1E0;
    branch_comp_pass = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) step("C add", 8'(i), 1'b1);
    step("C bne", 8'd4, 1'b0);
    step_halt("C halt", 8'd5);
    chk("C count", instr_count, 5);

    // Wait states: memory answers on the fifth FETCH cycle
    lat = 4;
    mem[0] = 9'h002; mem[1] = 9'h1E0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      chk("D wait req", inst_req, 1);
      chk("D wait addr", inst_addr, 0);
      tick();
    end
    chk("D dec req", inst_req, 0);
    chk("D dec raddr", reg_addr, 2);
    chk("D dec count", instr_count, 0);
    tick();
    chk("D exec we", reg_we, 1);
    tick();
    chk("D count", instr_count, 1);
    step_halt("D halt", 8'd1);
    chk("D count end", instr_count, 1);
    lat = 0;

    // Wrap-around 255 -> 0, then reset during EXEC (with start held too)
    mem[0] = 9'h189; mem[255] = 9'h003;
    alu_result = 8'hFF; branch_comp_pass = 1'b1;
    do_start();
    step("E bne", 8'd0, 1'b0);
    step("E add255", 8'd255, 1'b1);
    chk("E wrap addr", inst_addr, 0);
    chk("E count", instr_count, 2);
    mem[0] = 9'h003;
    tick();
    tick();
    chk("E exec we", reg_we, 1);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("E rst busy", busy, 0);
    chk("E rst we", reg_we, 0);
    chk("E rst addr", inst_addr, 0);
    chk("E rst count", instr_count, 0);
    chk("E rst req", inst_req, 0);
    chk("E rst raddr", reg_addr, 0);
    tick();
    chk("E idle busy", busy, 0);
    do_start();
    chk("E restart req", inst_req, 1);
    chk("E restart addr", inst_addr, 0);

    // Reset while an instruction response is pending: it must be dropped
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("F busy", busy, 0);
    chk("F raddr", reg_addr, 0);
    chk("F op", alu_op, 0);
    chk("F req", inst_req, 0);
    tick();
    chk("F still idle", busy, 0);
    chk("F we", reg_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
